// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: instruction encodings and fetch FSM state type.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: loads {pc, instr, valid=1}, inserts a bubble, or holds.
module if_id_register #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    // Bubble keeps the last pc; only instr/valid mark the slot as empty.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (bubble) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load) begin
            pc_d    = pc_in;
            instr_d = instr_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out    = pc_q;
    assign instr_out = instr_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, BOOT/RUN/HALT control, fetch counter, IF/ID register.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned IMEM_ADDR_W = 10,
    parameter logic [31:0] NOP_INSTR   = riscv_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    input  logic                   resume,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_instr,
    output logic [31:0]            if_id_pc,
    output logic [31:0]            if_id_instr,
    output logic                   if_id_valid,
    output logic                   halted,
    output logic [31:0]            fetch_count
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                   misalign
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  count_q, count_d;
    logic         ifid_load, ifid_bubble;
    logic [31:0]  redirect_tgt;

    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic redirect_mis;
    assign redirect_mis = (redirect_pc[1:0] != 2'b00);
    assign misalign     = misalign_q;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d  = misalign_q;
`endif
        unique case (state_q)
            BOOT: begin
                ifid_bubble = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                if (redirect) begin
                    pc_d        = redirect_tgt;
                    ifid_bubble = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (redirect_mis) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end
`endif
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_q + 32'd4;
                    count_d   = count_q + 32'd1;
                    if (imem_instr == EBREAK_INSTR) begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                ifid_bubble = 1'b1;
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
                    // A misaligned redirect re-traps instead of leaving HALT.
                    misalign_d = 1'b0;
                    if (redirect_mis) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end
`endif
                end else if (resume) begin
                    state_d = RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
                    misalign_d = 1'b0;
`endif
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            count_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    if_id_register #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .pc_in    (pc_q),
        .instr_in (imem_instr),
        .pc_out   (if_id_pc),
        .instr_out(if_id_instr),
        .valid_out(if_id_valid)
    );

    assign imem_addr   = pc_q[IMEM_ADDR_W+1:2];
    assign halted      = (state_q == HALT);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios then random stimulus
// against a behavioural fetch model. Honours FETCH_MISALIGN_TRAP_EN.
module tb_instruction_fetch;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect, resume;
    logic [31:0] redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_pc, if_id_instr, fetch_count;
    logic        if_id_valid, halted;
    logic        misalign;

    logic [31:0] mem [0:1023];
    assign imem_instr = mem[imem_addr];

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC   (RESET_PC),
        .IMEM_ADDR_W(10),
        .NOP_INSTR  (NOP_INSTR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .resume     (resume),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .if_id_pc   (if_id_pc),
        .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid),
        .halted     (halted),
        .fetch_count(fetch_count)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign   (misalign)
`endif
    );
`ifndef FETCH_MISALIGN_TRAP_EN
    assign misalign = 1'b0;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_ifpc, m_instr, m_cnt;
    bit          m_valid, m_boot, m_halt, m_mis;

    function automatic void model_reset();
        m_pc = RESET_PC; m_ifpc = '0; m_instr = NOP_INSTR; m_valid = 0;
        m_cnt = '0; m_boot = 1; m_halt = 0; m_mis = 0;
    endfunction

    function automatic void model_step();
        logic [31:0] tgt;
        logic [31:0] word;
        bit          mis;
        tgt = {redirect_pc[31:2], 2'b00};
        mis = TRAP && (redirect_pc[1:0] != 2'b00);
        if (m_boot) begin
            m_boot = 0; m_valid = 0; m_instr = NOP_INSTR;
        end else if (m_halt) begin
            m_valid = 0; m_instr = NOP_INSTR;
            if (redirect) begin
                m_pc = tgt;
                if (mis) m_mis = 1;
                else begin m_halt = 0; m_mis = 0; end
            end else if (resume) begin
                m_halt = 0; m_mis = 0;
            end
        end else if (redirect) begin
            m_pc = tgt; m_valid = 0; m_instr = NOP_INSTR;
            if (mis) begin m_mis = 1; m_halt = 1; end
        end else if (!stall) begin
            word = mem[m_pc[11:2]];
            m_ifpc = m_pc; m_instr = word; m_valid = 1;
            m_pc = m_pc + 4; m_cnt = m_cnt + 1;
            if (word == EBREAK_INSTR) m_halt = 1;
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".imem_addr"}, {22'd0, imem_addr}, {22'd0, m_pc[11:2]});
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        check({tag, ".instr"}, if_id_instr, m_instr);
        if (m_valid) check({tag, ".if_id_pc"}, if_id_pc, m_ifpc);
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halt});
        check({tag, ".count"}, fetch_count, m_cnt);
        if (TRAP) check({tag, ".misalign"}, {31'd0, misalign}, {31'd0, m_mis});
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic set_in(input bit s, input bit r, input logic [31:0] rpc, input bit res);
        stall = s; redirect = r; redirect_pc = rpc; resume = res;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all(tag);
        check({tag, ".if_id_pc"}, if_id_pc, 32'h0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            if (mem[i] == EBREAK_INSTR) mem[i] = mem[i] ^ 32'h1;
        end
        mem[0] = 32'hA0A0_0001; mem[1] = 32'hB0B0_0002;
        mem[2] = 32'hC0C0_0003; mem[3] = 32'hD0D0_0004;
        mem[4] = EBREAK_INSTR;

        rst_n = 1'b0;
        set_in(0, 0, 32'h0, 0);
        #7;
        model_reset();
        compare_all("reset");
        check("reset.if_id_pc", if_id_pc, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        cycle("boot");
        cycle("fetchA");
        cycle("fetchB");
        set_in(1, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) cycle("stall");
        check("stall.pc", {22'd0, imem_addr}, 32'd2);
        set_in(0, 0, 32'h0, 0);
        cycle("fetchC");
        cycle("fetchD");
        check("abcd.count", fetch_count, 32'd4);
        cycle("ebreak");
        check("ebreak.instr", if_id_instr, EBREAK_INSTR);
        set_in(1, 0, 32'h0, 0);
        cycle("halt_stall");
        set_in(0, 0, 32'h0, 0);
        cycle("halt_bubble");
        set_in(0, 0, 32'h0, 1);
        cycle("resume");
        set_in(0, 0, 32'h0, 0);
        cycle("after_resume");
        check("after_resume.pc", if_id_pc, 32'h14);
        set_in(1, 1, 32'h40, 0);
        cycle("redir_stall");
        set_in(0, 0, 32'h0, 0);
        cycle("redir_target");
        check("redir_target.pc", if_id_pc, 32'h40);
        set_in(0, 1, 32'hFFFF_FFFC, 0);
        cycle("redir_top");
        set_in(0, 0, 32'h0, 0);
        cycle("alias_top");
        cycle("wrap_zero");
        async_reset("async_rst");
        cycle("reboot");
        cycle("refetch0");
        set_in(0, 1, 32'h42, 0);
        cycle("redir_42");
        set_in(0, 0, 32'h0, 1);
        cycle("redir_42_resume");
        set_in(0, 0, 32'h0, 0);
        cycle("redir_42_fetch");

        for (int i = 0; i < 1024; i++)
            if ($urandom_range(15) == 0) mem[i] = EBREAK_INSTR;

        for (int n = 0; n < 2000; n++) begin
            set_in($urandom_range(3) == 0,
                   $urandom_range(9) == 0,
                   ($urandom_range(1) == 0) ? 32'($urandom_range(255)) : $urandom,
                   $urandom_range(2) == 0);
            cycle("rand");
            if (n == 1000) async_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
